// File: rtl/iomem_cmd_master.sv
// ---------------------------------------------------------------------------
// iomem_cmd_master
//
// Bridges a byte stream from a host (e.g. a debug UART) onto the SoC iomem
// bus as an initiator. Command packets arriving on rx are decoded, turned into
// a single 32-bit read or write bus cycle, and a status/data packet is sent
// back on tx.
//
//   Write : 0x57, addr[4], strb[1], data[4]  -> 'K' (0x4B) or 'T' (0x54)
//   Read  : 0x52, addr[4]                    -> 'K' + rdata[4], or 'T'
//   Other : any opcode                       -> '?' (0x3F)
//   Multi-byte fields are sent LSB first.
//
// Parameters:
//   TIMEOUT      max cycles iomem_valid is held without iomem_ready (0 = off)
//
// Ports:
//   clk, resetn  clock and synchronous active-low reset
//   rx_*         command byte stream in (valid/ready handshake)
//   tx_*         response byte stream out (valid/ready handshake)
//   iomem_*      bus initiator signals; wstrb == 0 marks a read
// ---------------------------------------------------------------------------
module iomem_cmd_master #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata
);

  localparam logic [7:0] OP_WRITE  = 8'h57;
  localparam logic [7:0] OP_READ   = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_TMO   = 8'h54;
  localparam logic [7:0] RSP_BADOP = 8'h3F;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    STRB,
    DATA,
    BUS,
    RESP
  } state_t;

  state_t      state;
  logic        armed;
  logic [1:0]  byte_cnt;
  logic        is_write;
  logic [31:0] tmo_cnt;
  logic [31:0] rdata_buf;
  logic [2:0]  resp_left;

  logic rx_fire;
  logic tx_fire;
  logic tmo_hit;

  // armed keeps rx_ready low while in reset even though the state is IDLE;
  // it rises on the first edge after resetn is released.
  assign rx_ready = armed && ((state == IDLE) || (state == ADDR) ||
                              (state == STRB) || (state == DATA));
  assign rx_fire  = rx_valid && rx_ready;
  assign tx_fire  = tx_valid && tx_ready;

  // tmo_cnt holds the number of BUS cycles already elapsed, so the edge that
  // ends cycle number TIMEOUT is the one where tmo_cnt == TIMEOUT-1.
  assign tmo_hit  = (TIMEOUT != 0) && (tmo_cnt == 32'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      armed       <= 1'b0;
      byte_cnt    <= 2'd0;
      is_write    <= 1'b0;
      tmo_cnt     <= 32'd0;
      rdata_buf   <= 32'd0;
      resp_left   <= 3'd0;
      tx_valid    <= 1'b0;
      tx_data     <= 8'h00;
      iomem_valid <= 1'b0;
      iomem_wstrb <= 4'h0;
      iomem_addr  <= 32'd0;
      iomem_wdata <= 32'd0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (rx_fire) begin
            byte_cnt <= 2'd0;
            if (rx_data == OP_WRITE) begin
              is_write <= 1'b1;
              state    <= ADDR;
            end else if (rx_data == OP_READ) begin
              is_write    <= 1'b0;
              iomem_wstrb <= 4'h0;
              iomem_wdata <= 32'd0;
              state       <= ADDR;
            end else begin
              tx_data   <= RSP_BADOP;
              tx_valid  <= 1'b1;
              resp_left <= 3'd1;
              state     <= RESP;
            end
          end
        end

        // Fields arrive LSB first, so shifting each byte in from the top
        // leaves the word correctly assembled after the fourth byte.
        ADDR: begin
          if (rx_fire) begin
            iomem_addr <= {rx_data, iomem_addr[31:8]};
            byte_cnt   <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (is_write) begin
                state <= STRB;
              end else begin
                iomem_valid <= 1'b1;
                tmo_cnt     <= 32'd0;
                state       <= BUS;
              end
            end
          end
        end

        STRB: begin
          if (rx_fire) begin
            iomem_wstrb <= rx_data[3:0];
            byte_cnt    <= 2'd0;
            state       <= DATA;
          end
        end

        // A write with no enabled byte lanes never touches the bus.
        DATA: begin
          if (rx_fire) begin
            iomem_wdata <= {rx_data, iomem_wdata[31:8]};
            byte_cnt    <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (iomem_wstrb == 4'h0) begin
                tx_data   <= RSP_OK;
                tx_valid  <= 1'b1;
                resp_left <= 3'd1;
                state     <= RESP;
              end else begin
                iomem_valid <= 1'b1;
                tmo_cnt     <= 32'd0;
                state       <= BUS;
              end
            end
          end
        end

        // Ready is checked before the timeout so a coincident completion
        // still reports success.
        BUS: begin
          if (iomem_ready) begin
            iomem_valid <= 1'b0;
            rdata_buf   <= iomem_rdata;
            tx_data     <= RSP_OK;
            tx_valid    <= 1'b1;
            resp_left   <= is_write ? 3'd1 : 3'd5;
            state       <= RESP;
          end else if (tmo_hit) begin
            iomem_valid <= 1'b0;
            tx_data     <= RSP_TMO;
            tx_valid    <= 1'b1;
            resp_left   <= 3'd1;
            state       <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end

        RESP: begin
          if (tx_fire) begin
            if (resp_left == 3'd1) begin
              tx_valid <= 1'b0;
              state    <= IDLE;
            end else begin
              tx_data   <= rdata_buf[7:0];
              rdata_buf <= {8'h00, rdata_buf[31:8]};
              resp_left <= resp_left - 3'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iomem_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_iomem_cmd_master
//
// Directed bench for iomem_cmd_master with TIMEOUT=8. Inputs are driven and
// outputs sampled on the falling clock edge; each scenario task checks its
// own results against hand-computed values.
// ---------------------------------------------------------------------------
module tb_iomem_cmd_master;

  logic        clk;
  logic        resetn;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  int errors = 0;
  int checks = 0;

  iomem_cmd_master #(.TIMEOUT(8)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one byte and returns at the falling edge after it was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL send_byte_wait: rx_ready=%0b required 1 for byte %02h", rx_ready, b);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  // Accepts one response byte; returns at the falling edge after the transfer.
  task automatic recv_byte(output logic [7:0] b);
    int n;
    tx_ready = 1'b1;
    n = 0;
    while (!tx_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!tx_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL recv_byte_wait: tx_valid=%0b required 1", tx_valid);
    end
    b = tx_data;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_ready, tx_valid, iomem_valid} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_flags: rx_ready/tx_valid/valid=%03b required 000",
               {rx_ready, tx_valid, iomem_valid});
    end
    checks++;
    if ({tx_data, iomem_wstrb, iomem_addr, iomem_wdata} !== 76'd0) begin
      errors++;
      $display("[TB] FAIL reset_data: tx_data=%02h wstrb=%h addr=%08h wdata=%08h required all 0",
               tx_data, iomem_wstrb, iomem_addr, iomem_wdata);
    end
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release: rx_ready=%0b required 1", rx_ready);
    end
  endtask

  task automatic test_write;
    logic [7:0] b;
    send_byte(8'h57);
    send_word(32'h03000000);
    send_byte(8'h0F);
    send_word(32'h0000005A);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (iomem_valid !== 1'b1 || iomem_addr !== 32'h03000000 ||
          iomem_wstrb !== 4'hF || iomem_wdata !== 32'h0000005A || rx_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL write_bus_c%0d: valid=%0b addr=%08h wstrb=%h wdata=%08h rx_ready=%0b required 1 03000000 f 0000005a 0",
                 c, iomem_valid, iomem_addr, iomem_wstrb, iomem_wdata, rx_ready);
      end
      if (c == 2) iomem_ready = 1'b1;
      @(negedge clk);
    end
    iomem_ready = 1'b0;
    checks++;
    if (iomem_valid !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h4B) begin
      errors++;
      $display("[TB] FAIL write_done: valid=%0b tx_valid=%0b tx_data=%02h required 0 1 4b",
               iomem_valid, tx_valid, tx_data);
    end
    recv_byte(b);
    checks++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL write_end: tx_valid=%0b rx_ready=%0b required 0 1", tx_valid, rx_ready);
    end
  endtask

  task automatic test_read;
    logic [7:0]  b;
    logic [39:0] expect_resp;
    expect_resp = 40'hDEADBEEF4B;
    send_byte(8'h52);
    send_word(32'h03001000);
    checks++;
    if (iomem_valid !== 1'b1 || iomem_wstrb !== 4'h0 ||
        iomem_addr !== 32'h03001000 || iomem_wdata !== 32'd0) begin
      errors++;
      $display("[TB] FAIL read_bus: valid=%0b wstrb=%h addr=%08h wdata=%08h required 1 0 03001000 00000000",
               iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata);
    end
    iomem_ready = 1'b1;
    iomem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    iomem_ready = 1'b0;
    iomem_rdata = 32'h0;
    checks++;
    if (iomem_valid !== 1'b0 || tx_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL read_done: valid=%0b tx_valid=%0b required 0 1", iomem_valid, tx_valid);
    end
    for (int i = 0; i < 5; i++) begin
      recv_byte(b);
      checks++;
      if (b !== expect_resp[8*i +: 8]) begin
        errors++;
        $display("[TB] FAIL read_byte%0d: got %02h required %02h", i, b, expect_resp[8*i +: 8]);
      end
    end
    checks++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL read_end: tx_valid=%0b rx_ready=%0b required 0 1", tx_valid, rx_ready);
    end
  endtask

  task automatic test_timeout;
    logic [7:0] b;
    int n;
    send_byte(8'h52);
    send_word(32'h00000040);
    n = 0;
    while (iomem_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("[TB] FAIL timeout_len: valid high %0d cycles required 8", n);
    end
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h54) begin
      errors++;
      $display("[TB] FAIL timeout_resp: tx_valid=%0b tx_data=%02h required 1 54", tx_valid, tx_data);
    end
    recv_byte(b);
    checks++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_single: tx_valid=%0b rx_ready=%0b required 0 1", tx_valid, rx_ready);
    end
    // Follow-up read completes normally.
    send_byte(8'h52);
    send_word(32'h00000044);
    iomem_ready = 1'b1;
    iomem_rdata = 32'h000000A7;
    @(negedge clk);
    iomem_ready = 1'b0;
    recv_byte(b);
    checks++;
    if (b !== 8'h4B) begin
      errors++;
      $display("[TB] FAIL timeout_next_k: got %02h required 4b", b);
    end
    recv_byte(b);
    checks++;
    if (b !== 8'hA7) begin
      errors++;
      $display("[TB] FAIL timeout_next_data: got %02h required a7", b);
    end
    repeat (3) recv_byte(b);
  endtask

  task automatic test_coincide;
    logic [7:0] b;
    send_byte(8'h52);
    send_word(32'h00000080);
    repeat (7) @(negedge clk);
    checks++;
    if (iomem_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL coincide_valid: valid=%0b required 1 on cycle 8", iomem_valid);
    end
    iomem_ready = 1'b1;
    iomem_rdata = 32'h01020304;
    @(negedge clk);
    iomem_ready = 1'b0;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h4B || iomem_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL coincide_resp: tx_valid=%0b tx_data=%02h valid=%0b required 1 4b 0",
               tx_valid, tx_data, iomem_valid);
    end
    repeat (5) recv_byte(b);
    checks++;
    if (b !== 8'h01) begin
      errors++;
      $display("[TB] FAIL coincide_last: got %02h required 01", b);
    end
  endtask

  task automatic test_back_pressure;
    logic [39:0] expect_resp;
    logic [3:0]  pat;
    int idx;
    int n;
    expect_resp = 40'h112233444B;
    pat = 4'b1001;
    send_byte(8'h52);
    send_word(32'h00000100);
    iomem_ready = 1'b1;
    iomem_rdata = 32'h11223344;
    @(negedge clk);
    iomem_ready = 1'b0;
    idx = 0;
    n = 0;
    while (idx < 5 && n < 40) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== expect_resp[8*idx +: 8] || rx_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_byte%0d_c%0d: tx_valid=%0b tx_data=%02h rx_ready=%0b required 1 %02h 0",
                 idx, n, tx_valid, tx_data, rx_ready, expect_resp[8*idx +: 8]);
      end
      tx_ready = pat[3 - (n % 4)];
      if (tx_ready) idx++;
      n++;
      @(negedge clk);
    end
    tx_ready = 1'b0;
    checks++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_end: tx_valid=%0b rx_ready=%0b required 0 1", tx_valid, rx_ready);
    end
  endtask

  task automatic test_bad_opcode;
    logic [7:0] b;
    send_byte(8'hA5);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h3F || rx_ready !== 1'b0 || iomem_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL badop_resp: tx_valid=%0b tx_data=%02h rx_ready=%0b valid=%0b required 1 3f 0 0",
               tx_valid, tx_data, rx_ready, iomem_valid);
    end
    recv_byte(b);
    checks++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL badop_end: tx_valid=%0b rx_ready=%0b required 0 1", tx_valid, rx_ready);
    end
  endtask

  task automatic test_zero_strobe;
    logic [7:0] b;
    send_byte(8'h57);
    send_word(32'h00000200);
    send_byte(8'hF0);
    send_word(32'hCAFEF00D);
    checks++;
    if (iomem_valid !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h4B) begin
      errors++;
      $display("[TB] FAIL zstrb_resp: valid=%0b tx_valid=%0b tx_data=%02h required 0 1 4b",
               iomem_valid, tx_valid, tx_data);
    end
    recv_byte(b);
    checks++;
    if (iomem_valid !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL zstrb_end: valid=%0b rx_ready=%0b required 0 1", iomem_valid, rx_ready);
    end
  endtask

  task automatic test_reset_midop;
    logic [7:0] b;
    // Reset while the bus request is outstanding.
    send_byte(8'h52);
    send_word(32'h00000300);
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if (iomem_valid !== 1'b0 || tx_valid !== 1'b0 || rx_ready !== 1'b0 || iomem_addr !== 32'd0) begin
      errors++;
      $display("[TB] FAIL rst_bus: valid=%0b tx_valid=%0b rx_ready=%0b addr=%08h required 0 0 0 0",
               iomem_valid, tx_valid, rx_ready, iomem_addr);
    end
    resetn = 1'b1;
    @(negedge clk);
    // Reset while a response is pending.
    send_byte(8'h52);
    send_word(32'h00000304);
    iomem_ready = 1'b1;
    iomem_rdata = 32'h55667788;
    @(negedge clk);
    iomem_ready = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL rst_resp: tx_valid=%0b tx_data=%02h required 0 00", tx_valid, tx_data);
    end
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_stray: tx_valid=%0b rx_ready=%0b required 0 1", tx_valid, rx_ready);
    end
    tx_ready = 1'b0;
    // A fresh write afterwards completes.
    send_byte(8'h57);
    send_word(32'h03000008);
    send_byte(8'h03);
    send_word(32'h0000BEEF);
    checks++;
    if (iomem_valid !== 1'b1 || iomem_addr !== 32'h03000008 ||
        iomem_wstrb !== 4'h3 || iomem_wdata !== 32'h0000BEEF) begin
      errors++;
      $display("[TB] FAIL rst_fresh_bus: valid=%0b addr=%08h wstrb=%h wdata=%08h required 1 03000008 3 0000beef",
               iomem_valid, iomem_addr, iomem_wstrb, iomem_wdata);
    end
    iomem_ready = 1'b1;
    @(negedge clk);
    iomem_ready = 1'b0;
    recv_byte(b);
    checks++;
    if (b !== 8'h4B || tx_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_fresh_resp: byte=%02h tx_valid=%0b required 4b 0", b, tx_valid);
    end
  endtask

  initial begin
    resetn      = 1'b0;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    tx_ready    = 1'b0;
    iomem_ready = 1'b0;
    iomem_rdata = 32'h0;
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_coincide();
    test_back_pressure();
    test_bad_opcode();
    test_zero_strobe();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
